// File: rtl/cfg_cmd_pkg.sv
// Shared constants, FSM state encoding and gain lookup for the config command engine.
package cfg_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    SPI_WAIT  = 3'd2,
    EEP_DUMMY = 3'd3,
    RESP_WAIT = 3'd4
  } state_t;

  localparam logic [7:0] OP_DUMP_CH  = 8'h01;
  localparam logic [7:0] OP_CFG_GAIN = 8'h02;
  localparam logic [7:0] OP_TRIG_LVL = 8'h03;
  localparam logic [7:0] OP_TRIG_POS = 8'h04;
  localparam logic [7:0] OP_SET_DEC  = 8'h05;
  localparam logic [7:0] OP_TRIG_CFG = 8'h06;
  localparam logic [7:0] OP_TRIG_RD  = 8'h07;
  localparam logic [7:0] OP_EEP_WRT  = 8'h08;
  localparam logic [7:0] OP_EEP_RD   = 8'h09;
  localparam logic [7:0] OP_CFG_RD   = 8'h0A;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  localparam logic [7:0]  TRIG_LVL_MIN   = 8'd46;
  localparam logic [7:0]  TRIG_LVL_MAX   = 8'd201;
  localparam logic [15:0] EEP_DUMMY_WORD = 16'hBCBC;

  // Analog front-end gain code -> SPI word for the channel's gain DAC.
  function automatic logic [15:0] gain_lut(input logic [2:0] g);
    logic [15:0] w;
    case (g)
      3'd0:    w = 16'h1302;
      3'd1:    w = 16'h1305;
      3'd2:    w = 16'h1309;
      3'd3:    w = 16'h1314;
      3'd4:    w = 16'h1328;
      3'd5:    w = 16'h1346;
      3'd6:    w = 16'h136B;
      default: w = 16'h13DD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cfg_cmd_engine_if.sv
// Host-side command/response handshake of the config command engine.
interface cfg_cmd_engine_if;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp_data, send_resp
  );

  modport slave (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp_data, send_resp
  );
endinterface

// File: rtl/cfg_cmd_wdog.sv
// SPI transfer watchdog: down-counter reloaded on each launched transfer,
// expired flags terminal count while the engine is still waiting for SPI_done.
module cfg_cmd_wdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD_VAL;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Reaching zero in the (TIMEOUT_CYC-1)th waiting cycle makes the
  // registered NAK land exactly TIMEOUT_CYC cycles after wrt_SPI.
  assign expired = run && (cnt == '0);

endmodule

// File: rtl/cfg_cmd_engine.sv
// Config command engine: decodes 24-bit host commands into config register
// writes, SPI transfers and responses. Optional watchdog: CFG_CMD_TIMEOUT_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for cmd_rdy; latches cmd
// DECODE    | single-cycle decode, launches SPI / response / dump
// SPI_WAIT  | first SPI transfer in flight, waiting for SPI_done
// EEP_DUMMY | EEPROM read dummy transfer in flight, data on its done
// RESP_WAIT | response presented, waiting for resp_sent
module cfg_cmd_engine
  import cfg_cmd_pkg::*;
#(
  parameter int         NUM_CH      = 3,
  parameter int         TRIG_POS_W  = 9,
  parameter int         TIMEOUT_CYC = 4096,
  parameter logic [2:0] EEP_SS      = 3'd7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cfg_cmd_engine_if.slave         host,
  output logic                    wrt_SPI,
  output logic [2:0]              ss,
  output logic [15:0]             SPI_data,
  input  logic                    SPI_done,
  input  logic [7:0]              EEP_data,
  output logic [7:0]              trig_cfg,
  output logic [TRIG_POS_W-1:0]   trig_pos,
  output logic [3:0]              decimator,
  output logic [3*NUM_CH-1:0]     afe_gain,
  output logic                    dump,
  output logic [2:0]              dump_ch,
  input  logic                    set_capture_done
);

  if (NUM_CH < 1 || NUM_CH > 6) begin : g_bad_num_ch
    $error("cfg_cmd_engine: NUM_CH must be 1..6");
  end
  if (TRIG_POS_W < 9 || TRIG_POS_W > 13) begin : g_bad_trig_pos_w
    $error("cfg_cmd_engine: TRIG_POS_W must be 9..13");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("cfg_cmd_engine: TIMEOUT_CYC must be at least 2");
  end

  state_t        state, state_nxt;
  logic [23:0]   cmd_q;
  logic [7:0]    opcode, byte2, byte3;
  logic          start;

  logic          clr_q, send_q;
  logic [7:0]    resp_q;

  logic          wrt_nxt, send_nxt, clr_nxt, dump_nxt;
  logic [7:0]    resp_nxt;
  logic [15:0]   spi_nxt;
  logic [2:0]    ss_nxt;
  logic          gain_we, tpos_we, dec_we, tcfg_we, dch_we;

  logic [3:0]    gain_ch;
  logic [2:0]    gain_val;
  logic          dump_ok, gain_ok, lvl_ok, cfg_rd_ok;
  logic [7:0]    cfg_rd_val;
  logic [15:0]   tpos_word;
  logic          wd_expired;

  assign opcode    = cmd_q[23:16];
  assign byte2     = cmd_q[15:8];
  assign byte3     = cmd_q[7:0];
  assign gain_ch   = byte2[3:0];
  assign gain_val  = byte2[6:4];
  assign tpos_word = {byte2, byte3};

  assign dump_ok = int'(byte2[2:0]) < NUM_CH;
  assign gain_ok = int'(gain_ch) < NUM_CH;
  assign lvl_ok  = (byte3 >= TRIG_LVL_MIN) && (byte3 <= TRIG_LVL_MAX);

  // clr_cmd_rdy is registered, so the host's cmd_rdy may still read high in
  // the IDLE cycle that carries the pulse; don't re-accept the old command.
  assign start = (state == IDLE) && host.cmd_rdy && !clr_q;

`ifdef CFG_CMD_TIMEOUT_EN
  logic waiting;
  assign waiting = (state == SPI_WAIT) || (state == EEP_DUMMY);

  cfg_cmd_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wrt_nxt),
    .run     (waiting),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    cfg_rd_ok  = 1'b1;
    cfg_rd_val = 8'h00;
    case (byte2)
      8'd0: cfg_rd_val = trig_pos[7:0];
      8'd1: cfg_rd_val = 8'(trig_pos >> 8);
      8'd2: cfg_rd_val = {4'h0, decimator};
      default: begin
        cfg_rd_ok = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
          if (int'(byte2) == n + 3) begin
            cfg_rd_ok  = 1'b1;
            cfg_rd_val = {5'h00, afe_gain[3*n +: 3]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_DUMP_CH:             state_nxt = dump_ok ? IDLE : RESP_WAIT;
          OP_CFG_GAIN:            state_nxt = gain_ok ? SPI_WAIT : RESP_WAIT;
          OP_TRIG_LVL:            state_nxt = lvl_ok ? SPI_WAIT : RESP_WAIT;
          OP_EEP_WRT, OP_EEP_RD:  state_nxt = SPI_WAIT;
          default:                state_nxt = RESP_WAIT;
        endcase
      end
      SPI_WAIT: begin
        if (SPI_done) begin
          state_nxt = (opcode == OP_EEP_RD) ? EEP_DUMMY : RESP_WAIT;
        end else if (wd_expired) begin
          state_nxt = RESP_WAIT;
        end
      end
      EEP_DUMMY: if (SPI_done || wd_expired) state_nxt = RESP_WAIT;
      RESP_WAIT: if (host.resp_sent) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wrt_nxt  = 1'b0;
    send_nxt = 1'b0;
    clr_nxt  = 1'b0;
    dump_nxt = 1'b0;
    resp_nxt = resp_q;
    spi_nxt  = SPI_data;
    ss_nxt   = ss;
    gain_we  = 1'b0;
    tpos_we  = 1'b0;
    dec_we   = 1'b0;
    tcfg_we  = 1'b0;
    dch_we   = 1'b0;
    case (state)
      DECODE: begin
        case (opcode)
          OP_DUMP_CH: begin
            if (dump_ok) begin
              dump_nxt = 1'b1;
              dch_we   = 1'b1;
              clr_nxt  = 1'b1;
            end else begin
              send_nxt = 1'b1;
              resp_nxt = NAK;
            end
          end
          OP_CFG_GAIN: begin
            if (gain_ok) begin
              gain_we = 1'b1;
              wrt_nxt = 1'b1;
              ss_nxt  = gain_ch[2:0] + 3'd1;
              spi_nxt = gain_lut(gain_val);
            end else begin
              send_nxt = 1'b1;
              resp_nxt = NAK;
            end
          end
          OP_TRIG_LVL: begin
            if (lvl_ok) begin
              wrt_nxt = 1'b1;
              ss_nxt  = 3'd0;
              spi_nxt = {8'h13, byte3};
            end else begin
              send_nxt = 1'b1;
              resp_nxt = NAK;
            end
          end
          OP_TRIG_POS: begin
            tpos_we  = 1'b1;
            send_nxt = 1'b1;
            resp_nxt = ACK;
          end
          OP_SET_DEC: begin
            dec_we   = 1'b1;
            send_nxt = 1'b1;
            resp_nxt = ACK;
          end
          OP_TRIG_CFG: begin
            tcfg_we  = 1'b1;
            send_nxt = 1'b1;
            resp_nxt = ACK;
          end
          OP_TRIG_RD: begin
            send_nxt = 1'b1;
            resp_nxt = trig_cfg;
          end
          OP_EEP_WRT: begin
            wrt_nxt = 1'b1;
            ss_nxt  = EEP_SS;
            spi_nxt = {2'b01, cmd_q[13:0]};
          end
          OP_EEP_RD: begin
            wrt_nxt = 1'b1;
            ss_nxt  = EEP_SS;
            spi_nxt = {2'b00, cmd_q[13:0]};
          end
          OP_CFG_RD: begin
            send_nxt = 1'b1;
            resp_nxt = cfg_rd_ok ? cfg_rd_val : NAK;
          end
          default: begin
            send_nxt = 1'b1;
            resp_nxt = NAK;
          end
        endcase
      end
      SPI_WAIT: begin
        if (SPI_done) begin
          if (opcode == OP_EEP_RD) begin
            wrt_nxt = 1'b1;
            spi_nxt = EEP_DUMMY_WORD;
          end else begin
            send_nxt = 1'b1;
            resp_nxt = ACK;
          end
        end else if (wd_expired) begin
          send_nxt = 1'b1;
          resp_nxt = NAK;
        end
      end
      EEP_DUMMY: begin
        if (SPI_done) begin
          send_nxt = 1'b1;
          resp_nxt = EEP_data;
        end else if (wd_expired) begin
          send_nxt = 1'b1;
          resp_nxt = NAK;
        end
      end
      RESP_WAIT: if (host.resp_sent) clr_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_SPI  <= 1'b0;
      send_q   <= 1'b0;
      clr_q    <= 1'b0;
      dump     <= 1'b0;
      resp_q   <= 8'h00;
      SPI_data <= 16'h0000;
      ss       <= EEP_SS;
    end else begin
      wrt_SPI  <= wrt_nxt;
      send_q   <= send_nxt;
      clr_q    <= clr_nxt;
      dump     <= dump_nxt;
      resp_q   <= resp_nxt;
      SPI_data <= spi_nxt;
      ss       <= ss_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= 24'h000000;
      trig_cfg  <= 8'h20;
      trig_pos  <= '0;
      decimator <= 4'h0;
      afe_gain  <= '0;
      dump_ch   <= 3'd0;
    end else begin
      if (start) cmd_q <= host.cmd;
      if (tpos_we) trig_pos <= tpos_word[TRIG_POS_W-1:0];
      if (dec_we) decimator <= byte3[3:0];
      if (dch_we) dump_ch <= byte2[2:0];
      for (int n = 0; n < NUM_CH; n++) begin
        if (gain_we && (int'(gain_ch) == n)) afe_gain[3*n +: 3] <= gain_val;
      end
      if (tcfg_we) trig_cfg <= {2'b00, byte2[5:0]};
      // Capture-done is sticky and wins over a concurrent TRIG_CFG write of bit 5.
      if (set_capture_done) trig_cfg[5] <= 1'b1;
    end
  end

  assign host.clr_cmd_rdy = clr_q;
  assign host.send_resp   = send_q;
  assign host.resp_data   = resp_q;

endmodule

// File: tb/tb_cfg_cmd_engine.sv
// Directed, table-driven bench for cfg_cmd_engine (optional CFG_CMD_TIMEOUT_EN case).
module tb_cfg_cmd_engine;

  localparam int         NUM_CH     = 3;
  localparam int         TRIG_POS_W = 9;
  localparam int         TB_TIMEOUT = 100;
  localparam logic [2:0] EEP_SS     = 3'd7;
  localparam logic [7:0] ACK_V      = 8'hA5;
  localparam logic [7:0] NAK_V      = 8'hEE;
  localparam int         NV         = 23;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  wrt_SPI;
  logic [2:0]            ss;
  logic [15:0]           SPI_data;
  logic                  SPI_done = 1'b0;
  logic [7:0]            EEP_data = 8'h3C;
  logic [7:0]            trig_cfg;
  logic [TRIG_POS_W-1:0] trig_pos;
  logic [3:0]            decimator;
  logic [3*NUM_CH-1:0]   afe_gain;
  logic                  dump;
  logic [2:0]            dump_ch;
  logic                  set_capture_done = 1'b0;

  always #5 clk = ~clk;

  cfg_cmd_engine_if host_if ();

  cfg_cmd_engine #(
    .NUM_CH      (NUM_CH),
    .TRIG_POS_W  (TRIG_POS_W),
    .TIMEOUT_CYC (TB_TIMEOUT),
    .EEP_SS      (EEP_SS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .host             (host_if.slave),
    .wrt_SPI          (wrt_SPI),
    .ss               (ss),
    .SPI_data         (SPI_data),
    .SPI_done         (SPI_done),
    .EEP_data         (EEP_data),
    .trig_cfg         (trig_cfg),
    .trig_pos         (trig_pos),
    .decimator        (decimator),
    .afe_gain         (afe_gain),
    .dump             (dump),
    .dump_ch          (dump_ch),
    .set_capture_done (set_capture_done)
  );

  typedef struct {
    logic [23:0] cmd;
    int          n_wrt;
    logic [15:0] spi0;
    logic [2:0]  ss0;
    logic [15:0] spi1;
    bit          resp;
    logic [7:0]  rv;
    bit          dmp;
    logic [2:0]  dch;
  } vec_t;

  vec_t vt [NV];

  int errors = 0;
  int checks = 0;

  int          n_wrt, n_dump, cyc_wrt, cyc_resp;
  logic [15:0] spi_w [2];
  logic [2:0]  ss_w [2];
  bit          got_resp;
  logic [7:0]  rv;
  logic [2:0]  dch_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one command; acts as host and SPI slave, recording what the DUT did.
  task automatic do_cmd(input logic [23:0] c, input bit withhold);
    int cyc = 0;
    int spi_dly = 0;
    int rs_dly = 0;
    bit fin = 1'b0;
    n_wrt = 0; n_dump = 0; cyc_wrt = 0; cyc_resp = 0;
    spi_w[0] = '0; spi_w[1] = '0; ss_w[0] = '0; ss_w[1] = '0;
    got_resp = 1'b0; rv = '0; dch_w = '0;
    host_if.cmd = c;
    host_if.cmd_rdy = 1'b1;
    while (!fin && cyc < TB_TIMEOUT + 200) begin
      @(negedge clk);
      cyc++;
      SPI_done = 1'b0;
      host_if.resp_sent = 1'b0;
      if (spi_dly > 0) begin
        spi_dly--;
        if (spi_dly == 0) SPI_done = 1'b1;
      end
      if (rs_dly > 0) begin
        rs_dly--;
        if (rs_dly == 0) begin
          host_if.resp_sent = 1'b1;
          chk($sformatf("resp_hold_%06h", c), host_if.resp_data, rv);
        end
      end
      if (wrt_SPI) begin
        if (n_wrt < 2) begin
          spi_w[n_wrt] = SPI_data;
          ss_w[n_wrt] = ss;
        end
        n_wrt++;
        cyc_wrt = cyc;
        if (!withhold) spi_dly = 2;
      end
      if (host_if.send_resp) begin
        got_resp = 1'b1;
        rv = host_if.resp_data;
        cyc_resp = cyc;
        rs_dly = 3;
      end
      if (dump) begin
        n_dump++;
        dch_w = dump_ch;
      end
      if (host_if.clr_cmd_rdy) begin
        host_if.cmd_rdy = 1'b0;
        fin = 1'b1;
      end
    end
    host_if.cmd_rdy = 1'b0;
    SPI_done = 1'b0;
    host_if.resp_sent = 1'b0;
    chk($sformatf("complete_%06h", c), fin, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int seen;
    int stray;

    vt[0]  = '{24'h021100, 1, 16'h1305, 3'd2, 16'h0, 1'b1, ACK_V, 1'b0, 3'd0};
    vt[1]  = '{24'h022300, 0, 16'h0,    3'd0, 16'h0, 1'b1, NAK_V, 1'b0, 3'd0};
    vt[2]  = '{24'h027200, 1, 16'h13DD, 3'd3, 16'h0, 1'b1, ACK_V, 1'b0, 3'd0};
    vt[3]  = '{24'h03002D, 0, 16'h0,    3'd0, 16'h0, 1'b1, NAK_V, 1'b0, 3'd0};
    vt[4]  = '{24'h0300C9, 1, 16'h13C9, 3'd0, 16'h0, 1'b1, ACK_V, 1'b0, 3'd0};
    vt[5]  = '{24'h03002E, 1, 16'h132E, 3'd0, 16'h0, 1'b1, ACK_V, 1'b0, 3'd0};
    vt[6]  = '{24'h0300CA, 0, 16'h0,    3'd0, 16'h0, 1'b1, NAK_V, 1'b0, 3'd0};
    vt[7]  = '{24'h041FFF, 0, 16'h0,    3'd0, 16'h0, 1'b1, ACK_V, 1'b0, 3'd0};
    vt[8]  = '{24'h0A0100, 0, 16'h0,    3'd0, 16'h0, 1'b1, 8'h01, 1'b0, 3'd0};
    vt[9]  = '{24'h0A0000, 0, 16'h0,    3'd0, 16'h0, 1'b1, 8'hFF, 1'b0, 3'd0};
    vt[10] = '{24'h05000B, 0, 16'h0,    3'd0, 16'h0, 1'b1, ACK_V, 1'b0, 3'd0};
    vt[11] = '{24'h0A0200, 0, 16'h0,    3'd0, 16'h0, 1'b1, 8'h0B, 1'b0, 3'd0};
    vt[12] = '{24'h0A0400, 0, 16'h0,    3'd0, 16'h0, 1'b1, 8'h01, 1'b0, 3'd0};
    vt[13] = '{24'h0A0500, 0, 16'h0,    3'd0, 16'h0, 1'b1, 8'h07, 1'b0, 3'd0};
    vt[14] = '{24'h0A0600, 0, 16'h0,    3'd0, 16'h0, 1'b1, NAK_V, 1'b0, 3'd0};
    vt[15] = '{24'h060100, 0, 16'h0,    3'd0, 16'h0, 1'b1, ACK_V, 1'b0, 3'd0};
    vt[16] = '{24'h070000, 0, 16'h0,    3'd0, 16'h0, 1'b1, 8'h01, 1'b0, 3'd0};
    vt[17] = '{24'h010200, 0, 16'h0,    3'd0, 16'h0, 1'b0, 8'h00, 1'b1, 3'd2};
    vt[18] = '{24'h010300, 0, 16'h0,    3'd0, 16'h0, 1'b1, NAK_V, 1'b0, 3'd0};
    vt[19] = '{24'h08C123, 1, 16'h4123, 3'd7, 16'h0, 1'b1, ACK_V, 1'b0, 3'd0};
    vt[20] = '{24'h090500, 2, 16'h0500, 3'd7, 16'hBCBC, 1'b1, 8'h3C, 1'b0, 3'd0};
    vt[21] = '{24'h0B0000, 0, 16'h0,    3'd0, 16'h0, 1'b1, NAK_V, 1'b0, 3'd0};
    vt[22] = '{24'h0A0300, 0, 16'h0,    3'd0, 16'h0, 1'b1, 8'h00, 1'b0, 3'd0};

    host_if.cmd = 24'h0;
    host_if.cmd_rdy = 1'b0;
    host_if.resp_sent = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_trig_cfg", trig_cfg, 32'h20);
    chk("rst_ss", ss, EEP_SS);
    chk("rst_trig_pos", trig_pos, 0);
    chk("rst_decimator", decimator, 0);
    chk("rst_afe_gain", afe_gain, 0);
    chk("rst_dump_ch", dump_ch, 0);
    chk("rst_spi_data", SPI_data, 0);
    chk("rst_resp_data", host_if.resp_data, 0);
    chk("rst_pulses", {wrt_SPI, host_if.send_resp, host_if.clr_cmd_rdy, dump}, 0);

    for (int i = 0; i < NV; i++) begin
      do_cmd(vt[i].cmd, 1'b0);
      chk($sformatf("v%0d_n_wrt", i), n_wrt, vt[i].n_wrt);
      if (vt[i].n_wrt > 0) begin
        chk($sformatf("v%0d_spi0", i), spi_w[0], vt[i].spi0);
        chk($sformatf("v%0d_ss0", i), ss_w[0], vt[i].ss0);
      end
      if (vt[i].n_wrt > 1) chk($sformatf("v%0d_spi1", i), spi_w[1], vt[i].spi1);
      chk($sformatf("v%0d_resp", i), got_resp, vt[i].resp);
      if (vt[i].resp) chk($sformatf("v%0d_resp_data", i), rv, vt[i].rv);
      chk($sformatf("v%0d_dump", i), n_dump, vt[i].dmp ? 1 : 0);
      if (vt[i].dmp) chk($sformatf("v%0d_dump_ch", i), dch_w, vt[i].dch);
      repeat (2) @(negedge clk);
    end

    chk("afe_gain_final", afe_gain, 9'h1C8);
    chk("trig_pos_final", trig_pos, 9'h1FF);
    chk("decimator_final", decimator, 4'hB);
    chk("dump_ch_final", dump_ch, 3'd2);
    chk("ss_held", ss, EEP_SS);
    chk("trig_cfg_written", trig_cfg, 8'h01);

    // Capture-done concurrent with a TRIG_CFG write clearing bit 5.
    set_capture_done = 1'b1;
    do_cmd(24'h060100, 1'b0);
    set_capture_done = 1'b0;
    chk("capdone_resp", rv, ACK_V);
    chk("capdone_trig_cfg", trig_cfg, 8'h21);
    repeat (2) @(negedge clk);

    // Reset while an EEPROM write is waiting for SPI_done.
    host_if.cmd = 24'h08C123;
    host_if.cmd_rdy = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (wrt_SPI) seen = 1;
    end
    chk("midrst_wrt_seen", seen, 1);
    @(negedge clk);
    rst_n = 1'b0;
    host_if.cmd_rdy = 1'b0;
    @(negedge clk);
    chk("midrst_trig_cfg", trig_cfg, 8'h20);
    chk("midrst_afe_gain", afe_gain, 0);
    chk("midrst_ss", ss, EEP_SS);
    chk("midrst_spi_data", SPI_data, 0);
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (host_if.send_resp || host_if.clr_cmd_rdy || wrt_SPI) stray++;
    end
    chk("midrst_no_resp", stray, 0);
    do_cmd(24'h0A0000, 1'b0);
    chk("midrst_alive_resp", rv, 8'h00);
    repeat (2) @(negedge clk);

`ifdef CFG_CMD_TIMEOUT_EN
    do_cmd(24'h021100, 1'b1);
    chk("tmo_n_wrt", n_wrt, 1);
    chk("tmo_resp", rv, NAK_V);
    chk("tmo_latency", cyc_resp - cyc_wrt, TB_TIMEOUT);
    chk("tmo_gain_kept", afe_gain[5:3], 3'd1);
    repeat (2) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
